// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   rx_state_t  - receive FSM states
//   UART_DATA_W - default data bits per frame
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: bit-period counter for the UART receiver.
//   clk, nrst  - clock, async active-low reset
//   clr        - synchronous clear to 0 (priority over enable)
//   enable     - count this cycle
//   max        - wrap value (bit period minus one)
//   half       - mid-bit compare value
//   count      - current count
//   tick       - count==max while enabled (wraps to 0 on this edge)
//   half_tick  - count==half while enabled
module rx_bit_counter
    import uart_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             enable,
    input  logic [CNT_W-1:0] max,
    input  logic [CNT_W-1:0] half,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             half_tick
);

    assign tick      = enable && (count == max);
    assign half_tick = enable && (count == half);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receive engine with held valid/read handshake.
//   clk, nrst     - clock, async active-low reset
//   en            - receiver enable; low aborts to IDLE
//   clks_per_bit  - bit period minus one (static while busy, min 3)
//   rx_in         - asynchronous serial line, idle high
//   rx_read       - consumer pulse: data_out taken
//   data_out      - last good byte
//   rx_valid      - good byte waiting
//   overrun       - sticky: byte completed while rx_valid high
//   framing_err   - one-cycle pulse: stop bit sampled low
//   busy          - FSM not in IDLE
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic [CNT_W-1:0]  clks_per_bit,
    input  logic              rx_in,
    input  logic              rx_read,
    output logic [DATA_W-1:0] data_out,
    output logic              rx_valid,
    output logic              overrun,
    output logic              framing_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic rx_m, rx_s, rx_p;
    rx_state_t state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shift;

    logic [CNT_W-1:0] count;
    logic             tick, half_tick;
    logic             cnt_clr, cnt_en;

    // Synchronizer and previous-sample flop reset high so a low line at
    // reset release is not seen as a falling edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    // Counter is held at 0 in IDLE, restarts after the start-bit midpoint so
    // every data/stop sample lands a full period later, mid-bit.
    assign cnt_clr = (state == IDLE) || !en || ((state == START) && half_tick);
    assign cnt_en  = (state != IDLE);

    rx_bit_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (cnt_clr),
        .enable    (cnt_en),
        .max       (clks_per_bit),
        .half      (clks_per_bit >> 1),
        .count     (count),
        .tick      (tick),
        .half_tick (half_tick)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            idx         <= '0;
            shift       <= '0;
            data_out    <= '0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            framing_err <= 1'b0;
            if (rx_read) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            if (!en) begin
                state <= IDLE;
                idx   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_s && rx_p) begin
                            state <= START;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (half_tick) begin
                            if (!rx_s) begin
                                state <= DATA;
                                idx   <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            // LSB arrives first and ends up in bit 0.
                            shift <= {rx_s, shift[DATA_W-1:1]};
                            idx   <= idx + 1'b1;
                            if (idx == LAST_IDX) state <= STOP;
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (rx_s) begin
                                // Load wins over a same-cycle rx_read.
                                data_out <= shift;
                                rx_valid <= 1'b1;
                                if (rx_valid && !rx_read) overrun <= 1'b1;
                            end else begin
                                framing_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              nrst, en, rx_in, rx_read;
    logic [CNT_W-1:0]  clks_per_bit;
    logic [DATA_W-1:0] data_out;
    logic              rx_valid, overrun, framing_err, busy;

    uart_rx_frame #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .clks_per_bit (clks_per_bit),
        .rx_in        (rx_in),
        .rx_read      (rx_read),
        .data_out     (data_out),
        .rx_valid     (rx_valid),
        .overrun      (overrun),
        .framing_err  (framing_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ferr_seen = 0;

    always @(negedge clk) if (framing_err === 1'b1) ferr_seen++;

    logic [DATA_W-1:0] exp_data;
    logic              exp_valid, exp_overrun;
    int                exp_ferr;

    task automatic model_frame(input logic [DATA_W-1:0] b, input bit stop_ok);
        if (stop_ok) begin
            if (exp_valid) exp_overrun = 1'b1;
            exp_valid = 1'b1;
            exp_data  = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic model_reset();
        exp_data = '0; exp_valid = 1'b0; exp_overrun = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        tick_n(n);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] b, input bit stop_bit,
                              input int len, input int read_at);
        int p;
        p = int'(clks_per_bit) + 1;
        for (int i = 0; i < len; i++) begin
            int bitn;
            bitn = i / p;
            if (bitn == 0)           rx_in = 1'b0;
            else if (bitn <= DATA_W) rx_in = b[3'(bitn - 1)];
            else                     rx_in = stop_bit;
            rx_read = (i == read_at);
            tick_n(1);
        end
        rx_read = 1'b0;
    endtask

    task automatic do_read();
        rx_read = 1'b1;
        tick_n(1);
        rx_read = 1'b0;
        exp_valid = 1'b0; exp_overrun = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; en = 1'b1; rx_in = 1'b1; rx_read = 1'b0; clks_per_bit = 16'd15;
        model_reset(); exp_ferr = 0;
        tick_n(3);
        checks++;
        if ({data_out, rx_valid, overrun, framing_err, busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 000", {data_out, rx_valid, overrun, framing_err, busy});
        end
        nrst = 1'b1;
        tick_n(5);
        checks++;
        if ({data_out, rx_valid, overrun, framing_err, busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_release: got %h expected 000", {data_out, rx_valid, overrun, framing_err, busy});
        end
    endtask

    task automatic test_basic_timing();
        clks_per_bit = 16'd15;
        idle(5);
        send_frame(8'hA5, 1'b1, 154, -1);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: rx_valid got %b expected 0", rx_valid);
        end
        tick_n(1);
        model_frame(8'hA5, 1'b1);
        checks++;
        if ({data_out, rx_valid, overrun, busy} !== {exp_data, exp_valid, exp_overrun, 1'b0}) begin
            errors++;
            $display("FAIL basic_load: got %h/%b/%b/%b expected %h/%b/%b/0",
                     data_out, rx_valid, overrun, busy, exp_data, exp_valid, exp_overrun);
        end
        idle(16);
        checks++;
        if (ferr_seen !== exp_ferr) begin
            errors++;
            $display("FAIL basic_ferr: got %0d expected %0d", ferr_seen, exp_ferr);
        end
        do_read();
        checks++;
        if ({rx_valid, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL basic_read: got %b%b expected 00", rx_valid, overrun);
        end
    endtask

    task automatic test_glitch();
        rx_in = 1'b0;
        tick_n(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy: got %b expected 1", busy);
        end
        idle(40);
        checks++;
        if ({rx_valid, overrun, busy} !== 3'b000 || ferr_seen !== exp_ferr) begin
            errors++;
            $display("FAIL glitch_nofrm: got %b%b%b ferr %0d expected 000 ferr %0d",
                     rx_valid, overrun, busy, ferr_seen, exp_ferr);
        end
    endtask

    task automatic test_framing_break();
        send_frame(8'h3C, 1'b0, 160, -1);
        model_frame(8'h3C, 1'b0);
        tick_n(48);
        checks++;
        if (ferr_seen !== exp_ferr) begin
            errors++;
            $display("FAIL break_ferr: got %0d expected %0d", ferr_seen, exp_ferr);
        end
        checks++;
        if ({data_out, rx_valid, busy} !== {exp_data, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL break_state: got %h/%b/%b expected %h/0/0", data_out, rx_valid, busy, exp_data);
        end
        idle(16);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 160, -1);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1, 160, -1);
        model_frame(8'h22, 1'b1);
        idle(16);
        checks++;
        if ({data_out, rx_valid, overrun} !== {exp_data, exp_valid, exp_overrun}) begin
            errors++;
            $display("FAIL overrun_set: got %h/%b/%b expected %h/%b/%b",
                     data_out, rx_valid, overrun, exp_data, exp_valid, exp_overrun);
        end
        do_read();
        checks++;
        if ({rx_valid, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_clr: got %b%b expected 00", rx_valid, overrun);
        end
    endtask

    task automatic test_read_on_load();
        send_frame(8'h55, 1'b1, 160, -1);
        model_frame(8'h55, 1'b1);
        idle(16);
        send_frame(8'h66, 1'b1, 160, 154);
        exp_data = 8'h66; exp_valid = 1'b1; exp_overrun = 1'b0;
        idle(16);
        checks++;
        if ({data_out, rx_valid, overrun} !== {exp_data, exp_valid, exp_overrun}) begin
            errors++;
            $display("FAIL read_on_load: got %h/%b/%b expected 66/1/0", data_out, rx_valid, overrun);
        end
    endtask

    task automatic test_abort_reset();
        send_frame(8'h81, 1'b1, 70, -1);
        nrst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({data_out, rx_valid, overrun, framing_err, busy} !== 12'h0) begin
            errors++;
            $display("FAIL abort_rst: got %h expected 000", {data_out, rx_valid, overrun, framing_err, busy});
        end
        tick_n(2);
        nrst = 1'b1;
        idle(16);
        send_frame(8'h81, 1'b1, 160, -1);
        model_frame(8'h81, 1'b1);
        idle(16);
        checks++;
        if ({data_out, rx_valid, overrun} !== {exp_data, exp_valid, exp_overrun}) begin
            errors++;
            $display("FAIL abort_rst_next: got %h/%b/%b expected %h/%b/%b",
                     data_out, rx_valid, overrun, exp_data, exp_valid, exp_overrun);
        end
    endtask

    task automatic test_abort_en();
        send_frame(8'h5A, 1'b1, 70, -1);
        en = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_en_pre: busy got %b expected 1", busy);
        end
        tick_n(1);
        checks++;
        if ({data_out, rx_valid, busy} !== {exp_data, exp_valid, 1'b0}) begin
            errors++;
            $display("FAIL abort_en: got %h/%b/%b expected %h/%b/0", data_out, rx_valid, busy, exp_data, exp_valid);
        end
        idle(20);
        en = 1'b1;
        idle(4);
        send_frame(8'h42, 1'b1, 160, -1);
        model_frame(8'h42, 1'b1);
        idle(16);
        checks++;
        if ({data_out, rx_valid, overrun} !== {exp_data, exp_valid, exp_overrun}) begin
            errors++;
            $display("FAIL abort_en_next: got %h/%b/%b expected %h/%b/%b",
                     data_out, rx_valid, overrun, exp_data, exp_valid, exp_overrun);
        end
        do_read();
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [DATA_W-1:0] b;
            bit stop_ok;
            int p;
            clks_per_bit = CNT_W'($urandom_range(3, 24));
            p = int'(clks_per_bit) + 1;
            b = DATA_W'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            idle(4);
            send_frame(b, stop_ok, 10 * p, -1);
            model_frame(b, stop_ok);
            idle(p + 2);
            checks++;
            if ({data_out, rx_valid, overrun, busy} !== {exp_data, exp_valid, exp_overrun, 1'b0} ||
                ferr_seen !== exp_ferr) begin
                errors++;
                $display("FAIL rand_%0d: got %h/%b/%b/%b ferr %0d expected %h/%b/%b/0 ferr %0d", n,
                         data_out, rx_valid, overrun, busy, ferr_seen,
                         exp_data, exp_valid, exp_overrun, exp_ferr);
            end
            if ($urandom_range(0, 1) == 1) begin
                do_read();
                checks++;
                if ({rx_valid, overrun} !== 2'b00) begin
                    errors++;
                    $display("FAIL rand_read_%0d: got %b%b expected 00", n, rx_valid, overrun);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_glitch();
        test_framing_break();
        test_overrun();
        test_read_on_load();
        test_abort_reset();
        test_abort_en();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receive engine for the team's UART path; counterpart to the transmit-side bit counter. Samples an asynchronous `rx_in` line at a programmable bit period, recovers 8N1 frames LSB-first, and presents each byte on a held valid/read handshake to the core. Reports framing errors and overruns.

## Interface
- `DATA_W`, 8: data bits per frame.
- `CNT_W`, 16: width of the bit-period counter and of `clks_per_bit`.
- `clk` in 1: system clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `en` in 1: receiver enable; low forces IDLE synchronously.
- `clks_per_bit` in CNT_W: bit period minus one, in clk cycles (P = clks_per_bit+1). Static while busy. Legal minimum is 3.
- `rx_in` in 1: asynchronous serial line, idle high.
- `rx_read` in 1: one-cycle pulse; consumer has taken `data_out`.
- `data_out` out DATA_W: last good byte; holds until the next good byte.
- `rx_valid` out 1: level; a good byte is waiting.
- `overrun` out 1: sticky; a byte completed while `rx_valid` was high.
- `framing_err` out 1: one-cycle pulse; the stop bit was sampled low.
- `busy` out 1: high in every state except IDLE.

## Operation
- `rx_in` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. The previous `rx_s` is kept as `rx_p` (reset value 1).
- States: IDLE, START, DATA, STOP.
- **IDLE:** on `rx_s`=0 and `rx_p`=1 (falling edge) with `en`=1, go to START. The bit counter clears.
- **START:** count to H = clks_per_bit>>1.
  - If `rx_s`=0 at that point, clear the counter, clear the bit index, and go to DATA.
  - Otherwise it is a false start: go to IDLE with no flags.
- **DATA:** the counter runs 0..clks_per_bit.
  - At count==clks_per_bit, sample `rx_s` into shift bit [index] (LSB first), wrap the counter, and increment the index.
  - After bit DATA_W-1, go to STOP.
- **STOP:** at count==clks_per_bit, sample the line and go to IDLE.
  - `rx_s`=1: load `data_out` and set `rx_valid`. If `rx_valid` was already 1 and `rx_read` is not asserted in the same cycle, set `overrun`.
  - `rx_s`=0: pulse `framing_err`. `data_out`, `rx_valid` and `overrun` are unchanged.
- A line held low after a framing error (break) does not restart reception. A new falling edge is required.
- `rx_read` clears `rx_valid` and `overrun` on the next edge.
- Load has priority over `rx_read` when both occur in the same cycle: `rx_valid` stays 1 and `overrun` is not set.
- `rx_read` with `rx_valid`=0 has no effect.
- `en`=0 mid-frame: go to IDLE and clear the counter and index. `data_out`, `rx_valid` and `overrun` are retained.
- Reset values: `data_out`=0, `rx_valid`=0, `overrun`=0, `framing_err`=0, `busy`=0, state IDLE.

## Timing
- Let t0 be the cycle in which IDLE detects the falling edge. `rx_s` lags `rx_in` by 2 cycles.
- Start sample: t0+1+H.
- Data bit k (0-based) sample: t0+1+H+(k+1)·P.
- Stop sample: t0+1+H+(DATA_W+1)·P.
- `rx_valid` and `data_out` update, or `framing_err` pulses, on the edge after the stop sample.
- Back in IDLE one cycle after the stop sample. Back-to-back frames are accepted with no gap beyond the stop bit.
- Mid-bit sampling tolerates about ±(H/P)/10 baud mismatch per frame. No oversampling or majority vote.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, STOP}.
  - `UART_DATA_W` = 8.
- Sub-module `rx_bit_counter`:
  - Ports: `clk`, `nrst`, `clr`, `enable`, `max`[CNT_W], `half`; outputs `count`, `tick`, `half_tick`.
  - `tick` is combinational when count==max, with wrap to 0.
- The top module holds the synchronizer, FSM, shift register, bit index (clog2(DATA_W)+1 bits) and output registers.

## Test plan
1. clks_per_bit=15, send 0xA5 (line 1 between frames) -> `data_out`=0xA5 and `rx_valid`=1 at t0+1+7+144+1. `framing_err` and `overrun` stay 0.
2. Glitch: `rx_in` low for 4 cycles, then high -> START false start returns to IDLE. No flags; `rx_valid` stays 0.
3. Send 0x3C with stop bit 0 -> `framing_err` pulses one cycle and `rx_valid` stays 0. Holding the line low afterwards produces no further frames.
4. Send 0x11 then 0x22 with no `rx_read` -> `data_out`=0x22, `rx_valid`=1, `overrun`=1. `rx_read` -> both clear next cycle.
5. Send 0x55 then 0x66, with `rx_read` asserted in the 0x66 load cycle -> `data_out`=0x66, `rx_valid`=1, `overrun`=0.
6. Cover both aborts mid-frame:
   - Assert `nrst`=0 during DATA bit 3 -> all outputs go to reset values immediately. The next clean frame 0x81 is received correctly.
   - Repeat with `en`=0 -> `busy` drops next cycle and the retained byte is unchanged.
